// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared definitions for the AHB round-robin arbiter.
//   arb_state_t  - arbiter FSM state encoding
//   HT_*         - htrans encodings
//   HB_*         - hburst encodings
//   burst_count  - beats remaining after the NONSEQ of a fixed-length burst
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_BURST = 2'd2,
    ARB_LOCK  = 2'd3
  } arb_state_t;

  localparam logic [1:0] HT_IDLE   = 2'd0;
  localparam logic [1:0] HT_BUSY   = 2'd1;
  localparam logic [1:0] HT_NONSEQ = 2'd2;
  localparam logic [1:0] HT_SEQ    = 2'd3;

  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;
  localparam logic [2:0] HB_WRAP4  = 3'd2;
  localparam logic [2:0] HB_INCR4  = 3'd3;
  localparam logic [2:0] HB_WRAP8  = 3'd4;
  localparam logic [2:0] HB_INCR8  = 3'd5;
  localparam logic [2:0] HB_WRAP16 = 3'd6;
  localparam logic [2:0] HB_INCR16 = 3'd7;

  // Zero means "not a fixed-length burst" (SINGLE / INCR).
  function automatic logic [3:0] burst_count(input logic [2:0] burst);
    logic [3:0] cnt;
    case (burst)
      HB_WRAP4,  HB_INCR4:  cnt = 4'd3;
      HB_WRAP8,  HB_INCR8:  cnt = 4'd7;
      HB_WRAP16, HB_INCR16: cnt = 4'd15;
      default:              cnt = 4'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin selector.
//   i_req  - request vector
//   i_ptr  - last granted index; search starts strictly after it and wraps,
//            so i_ptr itself is considered last
//   o_gnt  - one-hot winner (all zero when no request)
//   o_idx  - index of the winner
module rr_pick #(
  parameter int NM  = 4,
  parameter int IDW = 4
) (
  input  logic [NM-1:0]  i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [NM-1:0]  o_gnt,
  output logic [IDW-1:0] o_idx
);

  int w_best;
  int w_off;

  always_comb begin
    w_best = NM;
    w_off  = 0;
    o_idx  = '0;
    // Distance after the pointer; the smallest distance wins.
    for (int k = 0; k < NM; k++) begin
      w_off = (k - int'(i_ptr) - 1 + 2 * NM) % NM;
      if (i_req[k] && (w_off < w_best)) begin
        w_best = w_off;
        o_idx  = IDW'(k);
      end
    end
    o_gnt = '0;
    for (int k = 0; k < NM; k++) begin
      o_gnt[k] = (w_best < NM) && (o_idx == IDW'(k));
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: AHB bus arbiter, round-robin with burst and lock awareness.
//   hclk, hresetn        - bus clock, async active-low reset
//   hbusreq[NM]          - per-master request
//   hlock[NM]            - per-master locked-transfer request
//   htrans, hburst       - shared-bus transfer type / burst type
//   hready               - shared-bus transfer done; all state advances only when 1
//   hgrant[NM]           - registered one-hot grant
//   hmaster, hmaster_d   - address-phase / data-phase owner index
//   hmastlock            - address phase is locked
//
// state     | meaning
// ARB_IDLE  | no owner request, grant parked on DEFM
// ARB_OWN   | owner granted, may be re-arbitrated any cycle
// ARB_BURST | fixed-length burst in progress, hand over on the last SEQ
// ARB_LOCK  | owner holds hlock, grant frozen
module ahb_rr_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NM   = 4,
  parameter int IDW  = 4,
  parameter int DEFM = 0
) (
  input  logic           hclk,
  input  logic           hresetn,
  input  logic [NM-1:0]  hbusreq,
  input  logic [NM-1:0]  hlock,
  input  logic [1:0]     htrans,
  input  logic [2:0]     hburst,
  input  logic           hready,
  output logic [NM-1:0]  hgrant,
  output logic [IDW-1:0] hmaster,
  output logic [IDW-1:0] hmaster_d,
  output logic           hmastlock
);

  localparam logic [NM-1:0]  DEF_GNT = NM'(1) << DEFM;
  localparam logic [IDW-1:0] DEF_IDX = IDW'(DEFM);

  logic [NM-1:0]  r_grant;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_master;
  logic [IDW-1:0] r_master_d;
  logic           r_mastlock;
  arb_state_t     r_state;
  logic [3:0]     r_cnt;

  arb_state_t     w_st_eff;
  arb_state_t     w_state_nxt;
  logic [3:0]     w_cnt_eff;
  logic [3:0]     w_cnt_nxt;
  logic [IDW-1:0] w_own_idx;
  logic           w_own_lock;
  logic           w_early;
  logic           w_start;
  logic           w_hand;
  logic           w_any;
  logic [NM-1:0]  w_pick_gnt;
  logic [IDW-1:0] w_pick_idx;
  logic [NM-1:0]  w_grant_nxt;
  logic [IDW-1:0] w_ptr_nxt;

  rr_pick #(.NM(NM), .IDW(IDW)) u_pick (
    .i_req (hbusreq),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  always_comb begin
    w_own_idx = '0;
    for (int k = 0; k < NM; k++) begin
      if (r_grant[k]) w_own_idx = IDW'(k);
    end
  end

  assign w_own_lock = |(hlock & r_grant);
  assign w_any      = |hbusreq;
  assign w_early    = (r_state == ARB_BURST) && (r_cnt != 4'd0) &&
                      ((htrans == HT_IDLE) || (htrans == HT_NONSEQ));
  assign w_start    = (htrans == HT_NONSEQ) && (burst_count(hburst) != 4'd0);

  // Early-terminated bursts and released locks are re-evaluated as if the
  // arbiter were already in the state they fall back to.
  always_comb begin
    w_st_eff  = r_state;
    w_cnt_eff = r_cnt;
    if (w_early) begin
      w_st_eff  = ARB_OWN;
      w_cnt_eff = 4'd0;
    end else if ((r_state == ARB_LOCK) && !w_own_lock) begin
      w_st_eff = (r_cnt != 4'd0) ? ARB_BURST : ARB_OWN;
    end
  end

  always_comb begin
    w_cnt_nxt = w_cnt_eff;
    if (htrans == HT_NONSEQ)                         w_cnt_nxt = burst_count(hburst);
    else if ((htrans == HT_SEQ) && (w_cnt_eff != 0)) w_cnt_nxt = w_cnt_eff - 4'd1;
    else if (htrans == HT_IDLE)                      w_cnt_nxt = 4'd0;
  end

  assign w_hand = (htrans == HT_IDLE) || (w_st_eff == ARB_OWN) || (w_st_eff == ARB_IDLE) ||
                  ((w_st_eff == ARB_BURST) && (w_cnt_eff == 4'd1) && (htrans == HT_SEQ));

  // Priority: lock, then burst start, then handover.
  always_comb begin
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_state_nxt = w_st_eff;
    if (w_own_lock) begin
      w_state_nxt = ARB_LOCK;
    end else if (w_start) begin
      w_state_nxt = ARB_BURST;
    end else if (w_hand) begin
      if (w_any) begin
        w_grant_nxt = w_pick_gnt;
        w_ptr_nxt   = w_pick_idx;
        w_state_nxt = ARB_OWN;
      end else begin
        w_grant_nxt = DEF_GNT;
        w_state_nxt = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_grant    <= DEF_GNT;
      r_ptr      <= DEF_IDX;
      r_master   <= DEF_IDX;
      r_master_d <= DEF_IDX;
      r_mastlock <= 1'b0;
      r_state    <= ARB_IDLE;
      r_cnt      <= 4'd0;
    end else if (hready) begin
      r_grant    <= w_grant_nxt;
      r_ptr      <= w_ptr_nxt;
      r_master   <= w_own_idx;
      r_master_d <= r_master;
      r_mastlock <= w_own_lock;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign hgrant    = r_grant;
  assign hmaster   = r_master;
  assign hmaster_d = r_master_d;
  assign hmastlock = r_mastlock;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
module tb_ahb_rr_arbiter;
  import ahb_arb_pkg::*;

  logic       hclk = 1'b0;
  logic       hresetn = 1'b1;
  logic [3:0] hbusreq = '0;
  logic [3:0] hlock = '0;
  logic [1:0] htrans = HT_IDLE;
  logic [2:0] hburst = HB_SINGLE;
  logic       hready = 1'b1;
  logic [3:0] hgrant;
  logic [3:0] hmaster;
  logic [3:0] hmaster_d;
  logic       hmastlock;

  int n_total = 0;
  int n_bad   = 0;

  ahb_rr_arbiter #(.NM(4), .IDW(4), .DEFM(0)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmaster_d (hmaster_d),
    .hmastlock (hmastlock)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] req, input logic [3:0] lck,
                     input logic [1:0] tr, input logic [2:0] bu);
    hbusreq = req;
    hlock   = lck;
    htrans  = tr;
    hburst  = bu;
    @(posedge hclk);
    #1;
    chk("onehot", 32'($countones(hgrant)), 32'd1);
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    hready  = 1'b1;
    hbusreq = '0;
    hlock   = '0;
    htrans  = HT_IDLE;
    hburst  = HB_SINGLE;
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();
    chk("rst_grant", 32'(hgrant), 32'h1);
    chk("rst_hmaster", 32'(hmaster), 32'h0);
    chk("rst_hmaster_d", 32'(hmaster_d), 32'h0);
    chk("rst_mastlock", 32'(hmastlock), 32'h0);

    // Round robin with everyone requesting
    cyc(4'b1111, 4'b0000, HT_NONSEQ, HB_SINGLE); chk("rr_1", 32'(hgrant), 32'h2);
    chk("rr_hm_1", 32'(hmaster), 32'h0);
    cyc(4'b1111, 4'b0000, HT_NONSEQ, HB_SINGLE); chk("rr_2", 32'(hgrant), 32'h4);
    cyc(4'b1111, 4'b0000, HT_NONSEQ, HB_SINGLE); chk("rr_3", 32'(hgrant), 32'h8);
    chk("rr_hm_3", 32'(hmaster), 32'h2);
    chk("rr_hmd_3", 32'(hmaster_d), 32'h1);
    cyc(4'b1111, 4'b0000, HT_NONSEQ, HB_SINGLE); chk("rr_4", 32'(hgrant), 32'h1);
    cyc(4'b1111, 4'b0000, HT_NONSEQ, HB_SINGLE); chk("rr_5", 32'(hgrant), 32'h2);

    // Sole requester keeps the grant; no requester parks on DEFM
    do_reset();
    cyc(4'b0010, 4'b0000, HT_IDLE, HB_SINGLE);   chk("solo_get", 32'(hgrant), 32'h2);
    cyc(4'b0010, 4'b0000, HT_NONSEQ, HB_SINGLE); chk("solo_keep", 32'(hgrant), 32'h2);
    cyc(4'b1111, 4'b0000, HT_NONSEQ, HB_SINGLE); chk("solo_next", 32'(hgrant), 32'h4);
    cyc(4'b0000, 4'b0000, HT_IDLE, HB_SINGLE);   chk("park_def", 32'(hgrant), 32'h1);

    // INCR4 from M0 with M2 waiting
    do_reset();
    cyc(4'b0101, 4'b0000, HT_NONSEQ, HB_INCR4); chk("b4_ns", 32'(hgrant), 32'h1);
    cyc(4'b0101, 4'b0000, HT_SEQ, HB_INCR4);    chk("b4_s1", 32'(hgrant), 32'h1);
    cyc(4'b0101, 4'b0000, HT_SEQ, HB_INCR4);    chk("b4_s2", 32'(hgrant), 32'h1);
    cyc(4'b0101, 4'b0000, HT_SEQ, HB_INCR4);    chk("b4_last", 32'(hgrant), 32'h4);
    chk("b4_hm_old", 32'(hmaster), 32'h0);
    cyc(4'b0100, 4'b0000, HT_IDLE, HB_SINGLE);  chk("b4_hm_new", 32'(hmaster), 32'h2);

    // Lock held by M1 for 6 cycles while M0/M3 request
    do_reset();
    cyc(4'b0010, 4'b0000, HT_IDLE, HB_SINGLE); chk("lk_get", 32'(hgrant), 32'h2);
    for (int i = 0; i < 6; i++) begin
      cyc(4'b1011, 4'b0010, HT_NONSEQ, HB_SINGLE);
      chk("lk_hold", 32'(hgrant), 32'h2);
      chk("lk_hm", 32'(hmaster), 32'h1);
      chk("lk_mastlock", 32'(hmastlock), 32'h1);
    end
    cyc(4'b1011, 4'b0000, HT_NONSEQ, HB_SINGLE); chk("lk_release", 32'(hgrant), 32'h8);
    chk("lk_mastlock_off", 32'(hmastlock), 32'h0);

    // INCR8 terminated by IDLE after two beats
    do_reset();
    cyc(4'b0011, 4'b0000, HT_NONSEQ, HB_INCR8); chk("et_ns", 32'(hgrant), 32'h1);
    cyc(4'b0011, 4'b0000, HT_SEQ, HB_INCR8);    chk("et_s1", 32'(hgrant), 32'h1);
    cyc(4'b0011, 4'b0000, HT_IDLE, HB_SINGLE);  chk("et_hand", 32'(hgrant), 32'h2);
    cyc(4'b0011, 4'b0000, HT_SEQ, HB_INCR8);    chk("et_cleared", 32'(hgrant), 32'h1);

    // INCR16 with a 5-cycle hready stall after three beats
    do_reset();
    cyc(4'b0100, 4'b0000, HT_NONSEQ, HB_INCR16);
    cyc(4'b0100, 4'b0000, HT_SEQ, HB_INCR16);
    cyc(4'b0100, 4'b0000, HT_SEQ, HB_INCR16);
    hready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0100, 4'b0000, HT_IDLE, HB_SINGLE);
      chk("st_grant", 32'(hgrant), 32'h1);
      chk("st_hm", 32'(hmaster), 32'h0);
    end
    hready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(4'b0100, 4'b0000, HT_SEQ, HB_INCR16);
      chk("st_resume", 32'(hgrant), 32'h1);
    end
    cyc(4'b0100, 4'b0000, HT_SEQ, HB_INCR16); chk("st_last", 32'(hgrant), 32'h4);
    cyc(4'b0100, 4'b0000, HT_IDLE, HB_SINGLE); chk("st_hm_new", 32'(hmaster), 32'h2);

    // Async reset in the middle of WRAP8 owned by M1
    do_reset();
    cyc(4'b0010, 4'b0000, HT_IDLE, HB_SINGLE);
    cyc(4'b0010, 4'b0000, HT_NONSEQ, HB_WRAP8);
    cyc(4'b0010, 4'b0000, HT_SEQ, HB_WRAP8);
    chk("ar_pre_hm", 32'(hmaster), 32'h1);
    #2;
    hresetn = 1'b0;
    #1;
    chk("ar_grant", 32'(hgrant), 32'h1);
    chk("ar_hm", 32'(hmaster), 32'h0);
    chk("ar_hmd", 32'(hmaster_d), 32'h0);
    chk("ar_mastlock", 32'(hmastlock), 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    cyc(4'b1000, 4'b0000, HT_SEQ, HB_WRAP8); chk("ar_after", 32'(hgrant), 32'h8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_rr_arbiter.md
AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NM, default 4, giving the number of AHB requesting masters (2..8).
REQ-002 The block SHALL have parameter IDW, default 4, giving the hmaster ID width (must satisfy 2**IDW >= NM).
REQ-003 The block SHALL have parameter DEFM, default 0, giving the default (parked) master index.
REQ-004 hclk  input  1  bus clock, all state on rising edge.
REQ-005 hresetn  input  1  reset, asynchronous assert, active-low.
REQ-006 hbusreq  input  NM  per-master bus request.
REQ-007 hlock  input  NM  per-master locked-transfer request.
REQ-008 htrans  input  2  shared-bus transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-009 hburst  input  3  shared-bus burst type.
REQ-010 hready  input  1  shared-bus transfer done.
REQ-011 hgrant  output  NM  one-hot grant, registered.
REQ-012 hmaster  output  IDW  address-phase owner index.
REQ-013 hmaster_d  output  IDW  data-phase owner index.
REQ-014 hmastlock  output  1  current address phase is locked.

Function
REQ-015 All state SHALL update only on rising hclk with hready=1; with hready=0 every output and counter SHALL hold.
REQ-016 FSM states SHALL be ARB_IDLE (no owner request, DEFM parked), ARB_OWN (owner may be re-arbitrated), ARB_BURST (fixed-length burst in progress), ARB_LOCK (locked sequence).
REQ-017 Handover SHALL be allowed when htrans is IDLE, or in ARB_OWN, or in ARB_BURST when the beat counter equals 1 and htrans is SEQ; never in ARB_LOCK.
REQ-018 On handover the next grant SHALL be chosen round-robin: first requester strictly after the last granted index, wrapping NM-1 to 0; with no requester, hgrant SHALL go to DEFM and state to ARB_IDLE.
REQ-019 If the only requester is the current owner, the grant SHALL remain with it and the round-robin pointer SHALL not move.
REQ-020 On NONSEQ with hburst in {INCR4,WRAP4}, {INCR8,WRAP8} or {INCR16,WRAP16}, the beat counter SHALL load 3, 7 or 15 respectively and state SHALL go to ARB_BURST; each SEQ SHALL decrement it; BUSY SHALL not decrement.
REQ-021 SINGLE and INCR bursts SHALL not enter ARB_BURST; the counter is 4 bits and SHALL never wrap below 0.
REQ-022 An IDLE or NONSEQ seen in ARB_BURST before the counter reaches 0 (early termination) SHALL clear the counter and re-evaluate as a fresh transfer in the same cycle.
REQ-023 When the granted owner asserts hlock, state SHALL go to ARB_LOCK and hgrant SHALL hold until hlock drops and a non-locked handover condition is met.
REQ-024 hmaster SHALL take the index of hgrant one hready cycle after the grant changes; hmaster_d SHALL take hmaster one hready cycle later (one-cycle pipeline).
REQ-025 hmastlock SHALL equal the registered hlock of the address-phase owner, aligned with hmaster.
REQ-026 hgrant SHALL be one-hot at every cycle after reset.

Reset
REQ-027 Asserted hresetn SHALL asynchronously force hgrant to one-hot DEFM, hmaster and hmaster_d to DEFM, hmastlock to 0, counter to 0, round-robin pointer to DEFM, state ARB_IDLE, including mid-burst or mid-lock.
REQ-028 Release SHALL be used synchronously; the first arbitration SHALL occur on the first hready rising edge after release.

Structure
REQ-029 Package ahb_arb_pkg SHALL hold the FSM state enum, htrans/hburst constant encodings, and the burst-length-to-count function.
REQ-030 The round-robin selector SHALL be a sub-module rr_pick (inputs request vector and pointer, outputs one-hot and index).

Verification
REQ-031 NM=4, hbusreq=4'b1111 held, all SINGLE NONSEQ -> grants M1,M2,M3,M0,M1 on consecutive hready cycles.
REQ-032 M0 owns, NONSEQ INCR4 then 3 SEQ, M2 requesting -> hgrant stays M0 through beat 3, moves to M2 on the last SEQ; hmaster=2 one cycle later.
REQ-033 M1 hlock=1 for 6 cycles with M0/M3 requesting -> no grant change until hlock=0; hmastlock=1 aligned with hmaster=1.
REQ-034 INCR8 terminated by IDLE after 2 beats -> counter cleared, handover in that cycle.
REQ-035 hready=0 for 5 cycles mid-INCR16 -> counter, hgrant, hmaster frozen; resume counts remaining 13 beats.
REQ-036 hresetn asserted mid-WRAP8 -> hgrant=one-hot DEFM, hmaster=hmaster_d=DEFM immediately, no clock edge required.
